// File: rtl/dpram_pkg.sv
`timescale 1ns/1ps
// Shared definitions for dpram_be: per-port write-mode codes and the byte-lane merge helper.
package dpram_pkg;

    localparam int WR_FIRST  = 0;
    localparam int RD_FIRST  = 1;
    localparam int NO_CHANGE = 2;

    // Widest word the merge helper handles; callers size-cast in and out.
    localparam int MAX_DW = 1024;
    localparam int MAX_NB = MAX_DW / 8;

    function automatic logic [MAX_DW-1:0] byte_merge(
        input logic [MAX_DW-1:0] old_word,
        input logic [MAX_DW-1:0] new_word,
        input logic [MAX_NB-1:0] we
    );
        logic [MAX_DW-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_NB; i++) begin
            if (we[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dpram_port.sv
`timescale 1ns/1ps
// One read port of dpram_be: picks the returned word by write mode, applies the
// optional output register, and produces the one-cycle valid strobe.
module dpram_port
    import dpram_pkg::*;
#(
    parameter int DW      = 32,
    parameter int WMODE   = WR_FIRST,
    parameter int OUT_REG = 0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic          i_wr,
    input  logic [DW-1:0] i_old,
    input  logic [DW-1:0] i_new,
    output logic [DW-1:0] o_dout,
    output logic          o_vld
);

    logic          w_upd;
    logic [DW-1:0] w_data;
    logic [DW-1:0] r_q1;
    logic          r_v1;

    always_comb begin
        w_upd  = 1'b0;
        w_data = i_old;
        if (i_en) begin
            if (!i_wr) begin
                w_upd = 1'b1;
            end else begin
                case (WMODE)
                    WR_FIRST: begin
                        w_upd  = 1'b1;
                        w_data = i_new;
                    end
                    RD_FIRST: w_upd = 1'b1;
                    default:  w_upd = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q1 <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= w_upd;
            if (w_upd) begin
                r_q1 <= w_data;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DW-1:0] r_q2;
            logic          r_v2;

            // Second stage only loads on a valid beat so NO_CHANGE writes keep holding.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_q2 <= '0;
                    r_v2 <= 1'b0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_q2 <= r_q1;
                    end
                end
            end

            assign o_dout = r_q2;
            assign o_vld  = r_v2;
        end else begin : g_direct
            assign o_dout = r_q1;
            assign o_vld  = r_v1;
        end
    endgenerate

endmodule

// File: rtl/dpram_be.sv
`timescale 1ns/1ps
// dpram_be: true dual-port RAM with byte write enables on a single clock.
// Define DPRAM_COLL_EN to add the same-address collision pulse and saturating counter.
module dpram_be
    import dpram_pkg::*;
#(
    parameter        INIT_FILE = "",
    parameter int    DW        = 32,
    parameter int    DP        = 1024,
    parameter int    AW        = $clog2(DP),
    parameter int    NB        = DW / 8,
    parameter int    OUT_REG   = 0,
    parameter int    WMODE_A   = WR_FIRST,
    parameter int    WMODE_B   = WR_FIRST
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic [NB-1:0] wea,
    input  logic [AW-1:0] addra,
    input  logic [DW-1:0] dina,
    output logic [DW-1:0] douta,
    output logic          vlda,
    input  logic          enb,
    input  logic [NB-1:0] web,
    input  logic [AW-1:0] addrb,
    input  logic [DW-1:0] dinb,
    output logic [DW-1:0] doutb,
    output logic          vldb
`ifdef DPRAM_COLL_EN
    ,
    output logic          coll,
    output logic [7:0]    coll_cnt
`endif
);

    localparam logic [AW:0] DP_L = (AW+1)'(DP);

    logic [DW-1:0] r_mem [0:DP-1];

    logic          w_a_ok;
    logic          w_b_ok;
    logic          w_same;
    logic [DW-1:0] w_a_old;
    logic [DW-1:0] w_b_old;
    logic [NB-1:0] w_wea_x;
    logic [NB-1:0] w_web_x;
    logic [DW-1:0] w_a_new;
    logic [DW-1:0] w_b_new;

    assign w_a_ok  = ({1'b0, addra} < DP_L);
    assign w_b_ok  = ({1'b0, addrb} < DP_L);
    assign w_same  = (addra == addrb);
    assign w_a_old = w_a_ok ? r_mem[addra] : '0;
    assign w_b_old = w_b_ok ? r_mem[addrb] : '0;

    // Lanes the other port writes into this port's word in the same cycle.
    assign w_web_x = (enb && w_b_ok && w_same) ? web : '0;
    assign w_wea_x = (ena && w_a_ok && w_same) ? wea : '0;

    // Word as it will sit in memory after the edge; A is applied last so it wins shared lanes.
    assign w_a_new = w_a_ok ? DW'(byte_merge(
                         byte_merge(MAX_DW'(w_a_old), MAX_DW'(dinb), MAX_NB'(w_web_x)),
                         MAX_DW'(dina), MAX_NB'(wea))) : '0;
    assign w_b_new = w_b_ok ? DW'(byte_merge(
                         byte_merge(MAX_DW'(w_b_old), MAX_DW'(dinb), MAX_NB'(web)),
                         MAX_DW'(dina), MAX_NB'(w_wea_x))) : '0;

    // Port A's lane write is scheduled after B's, so it overrides on a shared lane.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (enb && w_b_ok && web[i]) begin
                r_mem[addrb][8*i +: 8] <= dinb[8*i +: 8];
            end
            if (ena && w_a_ok && wea[i]) begin
                r_mem[addra][8*i +: 8] <= dina[8*i +: 8];
            end
        end
    end

    dpram_port #(
        .DW      (DW),
        .WMODE   (WMODE_A),
        .OUT_REG (OUT_REG)
    ) u_port_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (ena),
        .i_wr    (|wea),
        .i_old   (w_a_old),
        .i_new   (w_a_new),
        .o_dout  (douta),
        .o_vld   (vlda)
    );

    dpram_port #(
        .DW      (DW),
        .WMODE   (WMODE_B),
        .OUT_REG (OUT_REG)
    ) u_port_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (enb),
        .i_wr    (|web),
        .i_old   (w_b_old),
        .i_new   (w_b_new),
        .o_dout  (doutb),
        .o_vld   (vldb)
    );

`ifdef DPRAM_COLL_EN
    logic       w_coll_now;
    logic       w_coll_out;
    logic       r_coll;
    logic [7:0] r_coll_cnt;

    assign w_coll_now = ena && enb && w_same && ((|wea) || (|web));

    generate
        if (OUT_REG != 0) begin : g_coll_pipe
            logic r_coll_p;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_coll_p <= 1'b0;
                end else begin
                    r_coll_p <= w_coll_now;
                end
            end
            assign w_coll_out = r_coll_p;
        end else begin : g_coll_direct
            assign w_coll_out = w_coll_now;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_coll     <= 1'b0;
            r_coll_cnt <= '0;
        end else begin
            r_coll <= w_coll_out;
            if (w_coll_out && (r_coll_cnt != 8'hFF)) begin
                r_coll_cnt <= r_coll_cnt + 8'd1;
            end
        end
    end

    assign coll     = r_coll;
    assign coll_cnt = r_coll_cnt;
`endif

endmodule

// File: tb/tb_dpram_be.sv
`timescale 1ns/1ps
// Directed bench for dpram_be: three instances share one stimulus stream
// (inst0 OUT_REG=0/A WR_FIRST, inst1 OUT_REG=1/A RD_FIRST, inst2 OUT_REG=0/A NO_CHANGE).
module tb_dpram_be;
    import dpram_pkg::*;

    localparam int DW = 32;
    localparam int DP = 12;
    localparam int AW = 4;
    localparam int NB = 4;
    localparam int OREG [3] = '{0, 1, 0};
    localparam int WMA  [3] = '{WR_FIRST, RD_FIRST, NO_CHANGE};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena, enb;
    logic [NB-1:0] wea, web;
    logic [AW-1:0] addra, addrb;
    logic [DW-1:0] dina, dinb;
    logic [DW-1:0] da [3];
    logic [DW-1:0] db [3];
    logic          va [3];
    logic          vb [3];
`ifdef DPRAM_COLL_EN
    logic          cl [3];
    logic [7:0]    cc [3];
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dpram_be #(
            .INIT_FILE (""),
            .DW        (DW),
            .DP        (DP),
            .AW        (AW),
            .NB        (NB),
            .OUT_REG   (OREG[g]),
            .WMODE_A   (WMA[g]),
            .WMODE_B   (WR_FIRST)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .ena      (ena),
            .wea      (wea),
            .addra    (addra),
            .dina     (dina),
            .douta    (da[g]),
            .vlda     (va[g]),
            .enb      (enb),
            .web      (web),
            .addrb    (addrb),
            .dinb     (dinb),
            .doutb    (db[g]),
            .vldb     (vb[g])
`ifdef DPRAM_COLL_EN
            ,
            .coll     (cl[g]),
            .coll_cnt (cc[g])
`endif
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
    endtask

    task automatic wr_b(input logic [AW-1:0] a, input logic [DW-1:0] d);
        enb = 1'b1; web = '1; addrb = a; dinb = d;
        tick();
        idle();
    endtask

    task automatic rd_a(input logic [AW-1:0] a);
        ena = 1'b1; wea = '0; addra = a;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        addra = '0; addrb = '0; dina = '0; dinb = '0;
        rst_n = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (da[i] !== 32'h0 || va[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_a inst%0d: douta=%h vlda=%b exp 0/0", i, da[i], va[i]);
            end
            checks++;
            if (db[i] !== 32'h0 || vb[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_b inst%0d: doutb=%h vldb=%b exp 0/0", i, db[i], vb[i]);
            end
`ifdef DPRAM_COLL_EN
            checks++;
            if (cl[i] !== 1'b0 || cc[i] !== 8'd0) begin
                errors++;
                $display("FAIL reset_coll inst%0d: coll=%b cnt=%0d exp 0/0", i, cl[i], cc[i]);
            end
`endif
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read();
        wr_b(4'd5, 32'hDEADBEEF);
        tick();
        rd_a(4'd5);
        checks++;
        if (da[0] !== 32'hDEADBEEF || va[0] !== 1'b1) begin
            errors++;
            $display("FAIL read_oreg0: douta=%h vlda=%b exp deadbeef/1", da[0], va[0]);
        end
        checks++;
        if (da[2] !== 32'hDEADBEEF || va[2] !== 1'b1) begin
            errors++;
            $display("FAIL read_nochange: douta=%h vlda=%b exp deadbeef/1", da[2], va[2]);
        end
        checks++;
        if (va[1] !== 1'b0) begin
            errors++;
            $display("FAIL read_oreg1_early: vlda=%b exp 0", va[1]);
        end
        tick();
        checks++;
        if (va[0] !== 1'b0 || da[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_oreg0_pulse: douta=%h vlda=%b exp deadbeef/0", da[0], va[0]);
        end
        checks++;
        if (da[1] !== 32'hDEADBEEF || va[1] !== 1'b1) begin
            errors++;
            $display("FAIL read_oreg1: douta=%h vlda=%b exp deadbeef/1", da[1], va[1]);
        end
        tick();
        checks++;
        if (va[1] !== 1'b0) begin
            errors++;
            $display("FAIL read_oreg1_pulse: vlda=%b exp 0", va[1]);
        end
    endtask

    task automatic test_byte_write();
        wr_b(4'd7, 32'h11223344);
        tick();
        ena = 1'b1; wea = 4'b0101; addra = 4'd7; dina = 32'hAABBCCDD;
        tick();
        idle();
        checks++;
        if (da[0] !== 32'h11BB33DD || va[0] !== 1'b1) begin
            errors++;
            $display("FAIL bw_wr_first: douta=%h vlda=%b exp 11bb33dd/1", da[0], va[0]);
        end
        checks++;
        if (da[2] !== 32'hDEADBEEF || va[2] !== 1'b0) begin
            errors++;
            $display("FAIL bw_no_change: douta=%h vlda=%b exp deadbeef/0", da[2], va[2]);
        end
        tick();
        checks++;
        if (da[1] !== 32'h11223344 || va[1] !== 1'b1) begin
            errors++;
            $display("FAIL bw_rd_first: douta=%h vlda=%b exp 11223344/1", da[1], va[1]);
        end
        enb = 1'b1; web = '0; addrb = 4'd7;
        tick();
        idle();
        checks++;
        if (db[0] !== 32'h11BB33DD || vb[0] !== 1'b1) begin
            errors++;
            $display("FAIL bw_read_b: doutb=%h vldb=%b exp 11bb33dd/1", db[0], vb[0]);
        end
    endtask

    task automatic test_write_modes();
        wr_b(4'd3, 32'h0);
        tick();
        ena = 1'b1; wea = 4'hF; addra = 4'd3; dina = 32'hFFFFFFFF;
        tick();
        idle();
        checks++;
        if (da[0] !== 32'hFFFFFFFF || va[0] !== 1'b1) begin
            errors++;
            $display("FAIL wm_wr_first: douta=%h vlda=%b exp ffffffff/1", da[0], va[0]);
        end
        checks++;
        if (da[2] !== 32'hDEADBEEF || va[2] !== 1'b0) begin
            errors++;
            $display("FAIL wm_no_change: douta=%h vlda=%b exp deadbeef/0", da[2], va[2]);
        end
        tick();
        checks++;
        if (da[1] !== 32'h0 || va[1] !== 1'b1) begin
            errors++;
            $display("FAIL wm_rd_first: douta=%h vlda=%b exp 0/1", da[1], va[1]);
        end
        rd_a(4'd3);
        checks++;
        if (da[2] !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL wm_readback: douta=%h exp ffffffff", da[2]);
        end
        tick();
    endtask

    task automatic test_collision();
        ena = 1'b1; wea = 4'hF; addra = 4'd9; dina = 32'h1;
        enb = 1'b1; web = 4'hF; addrb = 4'd9; dinb = 32'h2;
        tick();
        idle();
`ifdef DPRAM_COLL_EN
        checks++;
        if (cl[0] !== 1'b1 || cc[0] !== 8'd1) begin
            errors++;
            $display("FAIL coll_ww_oreg0: coll=%b cnt=%0d exp 1/1", cl[0], cc[0]);
        end
        checks++;
        if (cl[1] !== 1'b0) begin
            errors++;
            $display("FAIL coll_oreg1_early: coll=%b exp 0", cl[1]);
        end
`endif
        tick();
`ifdef DPRAM_COLL_EN
        checks++;
        if (cl[0] !== 1'b0 || cl[1] !== 1'b1 || cc[1] !== 8'd1) begin
            errors++;
            $display("FAIL coll_oreg1: coll0=%b coll1=%b cnt1=%0d exp 0/1/1", cl[0], cl[1], cc[1]);
        end
`endif
        ena = 1'b1; wea = '0; addra = 4'd9;
        enb = 1'b1; web = 4'hF; addrb = 4'd9; dinb = 32'h3;
        tick();
        idle();
        checks++;
        if (da[0] !== 32'h1 || va[0] !== 1'b1) begin
            errors++;
            $display("FAIL coll_rw_old: douta=%h vlda=%b exp 1/1", da[0], va[0]);
        end
`ifdef DPRAM_COLL_EN
        checks++;
        if (cc[0] !== 8'd2) begin
            errors++;
            $display("FAIL coll_rw_cnt: cnt=%0d exp 2", cc[0]);
        end
`endif
        enb = 1'b1; web = '0; addrb = 4'd9;
        tick();
        idle();
        checks++;
        if (db[0] !== 32'h3) begin
            errors++;
            $display("FAIL coll_rw_mem: doutb=%h exp 3", db[0]);
        end
        ena = 1'b1; wea = 4'b0011; addra = 4'd10; dina = 32'hAAAAAAAA;
        enb = 1'b1; web = 4'hF; addrb = 4'd10; dinb = 32'hBBBBBBBB;
        tick();
        idle();
        rd_a(4'd10);
        checks++;
        if (da[0] !== 32'hBBBBAAAA) begin
            errors++;
            $display("FAIL coll_lanes: douta=%h exp bbbbaaaa", da[0]);
        end
        ena = 1'b1; wea = 4'hF; addra = 4'd9; dina = 32'h1;
        enb = 1'b1; web = 4'hF; addrb = 4'd9; dinb = 32'h2;
        repeat (300) tick();
        idle();
        tick();
        tick();
`ifdef DPRAM_COLL_EN
        checks++;
        if (cc[0] !== 8'd255 || cc[1] !== 8'd255) begin
            errors++;
            $display("FAIL coll_sat: cnt0=%0d cnt1=%0d exp 255/255", cc[0], cc[1]);
        end
`endif
    endtask

    task automatic test_out_of_range();
        rd_a(4'd5);
        rd_a(4'd13);
        checks++;
        if (da[0] !== 32'h0 || va[0] !== 1'b1) begin
            errors++;
            $display("FAIL oor_read: douta=%h vlda=%b exp 0/1", da[0], va[0]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        ena = 1'b1; wea = '0; addra = 4'd5;
        tick();
        checks++;
        if (da[0] !== 32'hDEADBEEF || va[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_0_oreg0: douta=%h vlda=%b exp deadbeef/1", da[0], va[0]);
        end
        addra = 4'd7;
        tick();
        checks++;
        if (da[0] !== 32'h11BB33DD || va[0] !== 1'b1 || da[1] !== 32'hDEADBEEF || va[1] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_1: d0=%h v0=%b d1=%h v1=%b exp 11bb33dd/1 deadbeef/1", da[0], va[0], da[1], va[1]);
        end
        addra = 4'd3;
        tick();
        idle();
        checks++;
        if (da[0] !== 32'hFFFFFFFF || da[1] !== 32'h11BB33DD || va[1] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_2: d0=%h d1=%h v1=%b exp ffffffff 11bb33dd/1", da[0], da[1], va[1]);
        end
        tick();
        checks++;
        if (va[0] !== 1'b0 || da[1] !== 32'hFFFFFFFF || va[1] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_3: v0=%b d1=%h v1=%b exp 0 ffffffff/1", va[0], da[1], va[1]);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        ena = 1'b1; wea = '0; addra = 4'd5;
        tick();
        idle();
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        checks++;
        if (va[1] !== 1'b0 || da[1] !== 32'h0) begin
            errors++;
            $display("FAIL mid_rst_oreg1: douta=%h vlda=%b exp 0/0", da[1], va[1]);
        end
        checks++;
        if (da[0] !== 32'h0 || va[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_oreg0: douta=%h vlda=%b exp 0/0", da[0], va[0]);
        end
`ifdef DPRAM_COLL_EN
        checks++;
        if (cc[0] !== 8'd0) begin
            errors++;
            $display("FAIL mid_rst_cnt: cnt=%0d exp 0", cc[0]);
        end
`endif
        tick();
        checks++;
        if (va[1] !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_late: vlda=%b exp 0", va[1]);
        end
        rd_a(4'd5);
        tick();
        checks++;
        if (da[1] !== 32'hDEADBEEF || va[1] !== 1'b1) begin
            errors++;
            $display("FAIL mid_rst_mem: douta=%h vlda=%b exp deadbeef/1", da[1], va[1]);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_byte_write();
        test_write_modes();
        test_collision();
        test_out_of_range();
        test_back_to_back();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
